// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [NUM_ROWS-1:0] ROW_IDLE = 4'b1111;

  // Active-low one-hot drive pattern for the given row.
  function automatic logic [NUM_ROWS-1:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

  // Index of the lowest column pulled low; only meaningful when some column is low.
  function automatic logic [1:0] lowest_zero(input logic [NUM_COLS-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (!cols[c]) idx = 2'(c);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous level signals.
module keypad_sync
  import keypad_pkg::*;
#(
  parameter int               WIDTH       = NUM_COLS,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta;

  // Shift the raw input through two flops; the first may go metastable.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here so both flops sample the pre-edge values;
    // blocking would collapse the chain into a single stage.
    if (reset) begin
      meta   <= RESET_VALUE;
      synced <= RESET_VALUE;
    end else begin
      meta   <= data;
      synced <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scanning, press/release debounce, valid/ack key output.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_TICKS = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_in,
  input  logic       key_ack,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_pressed,
  output logic       overrun
);

  import keypad_pkg::*;

  localparam int TICK_W = $clog2(SCAN_TICKS);
  localparam int DB_W   = $clog2(DEBOUNCE_TICKS);

  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(SCAN_TICKS - 1);
  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [NUM_COLS-1:0] COL_IDLE  = '1;

  state_t              state, state_next;
  logic [1:0]          row_idx, row_next;
  logic [TICK_W-1:0]   tick, tick_next;
  logic [DB_W-1:0]     db_cnt, db_next;
  logic [NUM_COLS-1:0] cand, cand_next;
  logic [NUM_COLS-1:0] col_s;
  logic                accept, release_key;

  logic [NUM_ROWS-1:0] row_out_next;
  logic                valid_next, pressed_next, overrun_next;
  logic [3:0]          code_next;

  keypad_sync #(.WIDTH(NUM_COLS), .RESET_VALUE(COL_IDLE)) u_col_sync (
    .clock  (clock),
    .reset  (reset),
    .data   (col_in),
    .synced (col_s)
  );

  // State register: FSM state, scan position, dwell/debounce counters, candidate pattern.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= SCAN;
      row_idx <= 2'd0;
      tick    <= '0;
      db_cnt  <= '0;
      cand    <= COL_IDLE;
    end else begin
      state   <= state_next;
      row_idx <= row_next;
      tick    <= tick_next;
      db_cnt  <= db_next;
      cand    <= cand_next;
    end
  end

  // Next-state logic: scan dwell, press debounce, release debounce.
  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next  = state;
    row_next    = row_idx;
    tick_next   = tick;
    db_next     = db_cnt;
    cand_next   = cand;
    accept      = 1'b0;
    release_key = 1'b0;

    unique case (state)
      SCAN: begin
        // Sample only on the last dwell cycle so the row and synchronizer have settled.
        if (tick == TICK_LAST) begin
          tick_next = '0;
          if (col_s == COL_IDLE) begin
            row_next = row_idx + 2'd1;
          end else begin
            cand_next  = col_s;
            db_next    = '0;
            state_next = PRESS_DB;
          end
        end else begin
          tick_next = tick + TICK_W'(1);
        end
      end

      PRESS_DB: begin
        if (col_s == cand) begin
          if (db_cnt == DB_LAST) begin
            accept     = 1'b1;
            db_next    = '0;
            state_next = HELD;
          end else begin
            db_next = db_cnt + DB_W'(1);
          end
        end else begin
          // Pattern changed before it was stable long enough: rescan the same row.
          tick_next  = '0;
          state_next = SCAN;
        end
      end

      HELD: begin
        if (col_s == COL_IDLE) begin
          if (db_cnt == DB_LAST) begin
            release_key = 1'b1;
            db_next     = '0;
            tick_next   = '0;
            row_next    = row_idx + 2'd1;
            state_next  = SCAN;
          end else begin
            db_next = db_cnt + DB_W'(1);
          end
        end else begin
          db_next = '0;
        end
      end

      default: state_next = SCAN;
    endcase
  end

  // Output logic: next values of the registered outputs, acceptance overriding ack.
  always_comb begin
    row_out_next = row_drive(row_idx);
    valid_next   = key_valid;
    code_next    = key_code;
    pressed_next = key_pressed;
    overrun_next = overrun;

    if (key_valid && key_ack) valid_next = 1'b0;

    if (accept) begin
      valid_next   = 1'b1;
      pressed_next = 1'b1;
      // An unconsumed code is kept; the lost press is flagged instead.
      if (key_valid && !key_ack) overrun_next = 1'b1;
      else                       code_next    = {row_idx, lowest_zero(cand)};
    end

    if (release_key) pressed_next = 1'b0;
  end

  // Output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_out     <= ROW_IDLE;
      key_valid   <= 1'b0;
      key_code    <= 4'd0;
      key_pressed <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      row_out     <= row_out_next;
      key_valid   <= valid_next;
      key_code    <= code_next;
      key_pressed <= pressed_next;
      overrun     <= overrun_next;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical 4x4 key matrix model drives
// the column returns from the DUT's row drive; expectations come from key indices.
module tb_keypad_scanner;

  localparam int SCAN  = 8;
  localparam int DB    = 16;
  localparam int LIMIT = 300;

  localparam int VALID_HIGH   = 0;
  localparam int PRESSED_HIGH = 1;
  localparam int PRESSED_LOW  = 2;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic        key_ack = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic        overrun;

  logic [15:0] keys = '0;   // keys[row*4+col] = 1 while that key is held

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic valid_prev = 1'b0;

  keypad_scanner #(
    .SCAN_TICKS     (SCAN),
    .DEBOUNCE_TICKS (DB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .col_in      (col_in),
    .key_ack     (key_ack),
    .row_out     (row_out),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .overrun     (overrun)
  );

  always #10 clock = ~clock;

  // Key matrix: a held key shorts its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (row_out[r] === 1'b0 && keys[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  // Count rising edges of key_valid.
  always @(negedge clock) begin
    if (key_valid === 1'b1 && valid_prev !== 1'b1) rises++;
    valid_prev = key_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [3:0] drive_of(input int row);
    logic [3:0] v;
    v      = 4'b1111;
    v[row] = 1'b0;
    return v;
  endfunction

  // Lowest-numbered held key: the winner when all held keys share one row.
  function automatic logic [3:0] first_key(input logic [15:0] k);
    for (int i = 0; i < 16; i++) begin
      if (k[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  function automatic logic level_reached(input int what);
    case (what)
      VALID_HIGH:   return key_valid === 1'b1;
      PRESSED_HIGH: return key_pressed === 1'b1;
      default:      return key_pressed === 1'b0;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int what, output int cycles);
    cycles = 0;
    while (!level_reached(what) && cycles < LIMIT) begin
      @(negedge clock);
      cycles++;
    end
    check({tag, "_timeout"}, 32'(cycles < LIMIT), 1);
  endtask

  task automatic acknowledge(input string tag, input logic [3:0] code);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    check({tag, "_valid_cleared"}, key_valid, 0);
    check({tag, "_code_held"}, key_code, code);
  endtask

  task automatic release_all(input string tag);
    int n;
    keys = '0;
    wait_until({tag, "_release"}, PRESSED_LOW, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_out"}, row_out, 4'hF);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_code"}, key_code, 0);
    check({tag, "_pressed"}, key_pressed, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int n;
    int r0;
    int run;
    int row;
    logic [3:0] exp_code;
    logic seen;

    // 1. Reset and idle scan sequence.
    reset = 1'b1;
    step(3);
    check_reset_outputs("t1_reset");
    reset = 1'b0;
    for (int i = 0; i < 4 * SCAN + 8; i++) begin
      step(1);
      check($sformatf("t1_scan_%0d", i), row_out, drive_of((i / SCAN) % 4));
    end

    // 2. Row 2 / column 1 steady press, ack, release.
    keys[9] = 1'b1;
    wait_until("t2_accept", VALID_HIGH, n);
    check("t2_code", key_code, 4'h9);
    check("t2_pressed", key_pressed, 1);
    check("t2_row_frozen", row_out, 4'b1011);
    check("t2_overrun", overrun, 0);
    acknowledge("t2_ack", 4'h9);
    check("t2_still_pressed", key_pressed, 1);
    keys = '0;
    wait_until("t2_release", PRESSED_LOW, n);
    check("t2_release_min", 32'(n >= DB), 1);
    check("t2_release_max", 32'(n <= DB + 4), 1);
    step(1);
    check("t2_next_row", row_out, 4'b0111);

    // 3. Bouncing press on row 0 / column 3: exactly one acceptance.
    r0 = rises;
    for (int p = 0; p < 8; p++) begin
      keys[3] = (p % 2 == 0);
      step(5);
    end
    keys[3] = 1'b1;
    wait_until("t3_accept", VALID_HIGH, n);
    step(40);
    check("t3_one_edge", 32'(rises - r0), 1);
    check("t3_code", key_code, 4'h3);
    acknowledge("t3_ack", 4'h3);
    release_all("t3");

    // Randomized presses: one or two keys in a random row.
    for (int it = 0; it < 8; it++) begin
      row = int'($urandom_range(0, 3));
      keys = '0;
      keys[row*4 + int'($urandom_range(0, 3))] = 1'b1;
      if ($urandom_range(0, 1) == 1) keys[row*4 + int'($urandom_range(0, 3))] = 1'b1;
      exp_code = first_key(keys);
      wait_until($sformatf("rnd%0d_accept", it), VALID_HIGH, n);
      check($sformatf("rnd%0d_code", it), key_code, exp_code);
      check($sformatf("rnd%0d_row", it), row_out, drive_of(row));
      check($sformatf("rnd%0d_pressed", it), key_pressed, 1);
      step(int'($urandom_range(0, 6)));
      acknowledge($sformatf("rnd%0d_ack", it), exp_code);
      step(int'($urandom_range(0, 20)));
      release_all($sformatf("rnd%0d", it));
    end

    // 4. Unacknowledged key 5 followed by key 0xA: overrun.
    keys[5] = 1'b1;
    wait_until("t4_first", VALID_HIGH, n);
    check("t4_first_code", key_code, 4'h5);
    check("t4_no_overrun_yet", overrun, 0);
    release_all("t4_first");
    check("t4_valid_pending", key_valid, 1);
    keys[10] = 1'b1;
    wait_until("t4_second", PRESSED_HIGH, n);
    check("t4_overrun", overrun, 1);
    check("t4_valid", key_valid, 1);
    check("t4_code_kept", key_code, 4'h5);
    acknowledge("t4_ack", 4'h5);
    release_all("t4_second");

    // 5. Row 1 with columns 0 and 3 low: lowest column wins.
    keys[4] = 1'b1;
    keys[7] = 1'b1;
    wait_until("t5_accept", VALID_HIGH, n);
    check("t5_code", key_code, 4'h4);
    check("t5_overrun_sticky", overrun, 1);
    acknowledge("t5_ack", 4'h4);
    release_all("t5");

    // 6. Reset during press debounce (row 0 held well past its dwell).
    keys[0] = 1'b1;
    run = 0;
    n = 0;
    while (run < 12 && n < LIMIT) begin
      step(1);
      n++;
      if (row_out == 4'b1110) run++;
      else run = 0;
    end
    check("t6_frozen_timeout", 32'(n < LIMIT), 1);
    check("t6_not_accepted_yet", key_valid, 0);
    reset = 1'b1;
    keys  = '0;
    step(1);
    check_reset_outputs("t6_reset");
    reset = 1'b0;
    step(1);
    check("t6_restart_row", row_out, 4'b1110);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (key_valid !== 1'b0) seen = 1'b1;
    end
    check("t6_no_valid", seen, 0);
    check("t6_overrun_cleared", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
